// File: rtl/tikr_fb_pkg.sv
// tikr_frame_builder shared types: element and frame shapes, FSM states.
// Fill-order helper maps byte index k to the frame element it lands in.
package tikr_fb_pkg;

   typedef logic [1:0][2:2][4:1] elem_t;
   typedef elem_t frame_t [2:2][4:2][0:1][2:2];

   localparam int NELEM = 6;

   typedef elem_t [NELEM-1:0] ebuf_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      FULL = 2'd2,
      DROP = 2'd3
   } fb_state_e;

   typedef struct packed {
      logic [2:0] row;
      logic       col;
   } elem_idx_t;

   // k0,k1 -> row 4; k2,k3 -> row 3; k4,k5 -> row 2; even k -> col 0
   function automatic elem_idx_t elem_idx(input int k);
      elem_idx_t r;
      r.row = 3'(4 - k / 2);
      r.col = 1'(k % 2);
      return r;
   endfunction

   function automatic logic [7:0] elem_xor(input ebuf_t b);
      logic [7:0] x;
      x = '0;
      for (int i = 0; i < NELEM; i++) begin
         x = x ^ b[i];
      end
      return x;
   endfunction

endpackage

// File: rtl/tikr_fb_timer.sv
// Idle counter for partial frames; expire fires in the cycle
// whose edge would make the count reach limit. limit 0 never expires.
module tikr_fb_timer
   import tikr_fb_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic       en,
   input  logic [7:0] limit,
   output logic       expire
);

   logic [7:0] cnt_q, cnt_d;

   assign expire = en && (limit != 8'd0) &&
                   (cnt_q == limit - 8'd1);

   // count idle cycles, clear on any accepted byte or outside FILL
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && !expire) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   // counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/tikr_frame_builder.sv
// Assembles six accepted bytes into one tikr frame with a one-deep slot.
// Optional frame_chk output (XOR of elements) under TIKR_FB_XOR_CHK_EN.
module tikr_frame_builder
   import tikr_fb_pkg::*;
#(
   parameter int FRAME_TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   input  logic       in_last,
   output logic       in_ready,
   output frame_t     frame,
   output logic       frame_valid,
   input  logic       frame_ack,
   output logic       err_len,
   output logic       err_tmo,
`ifdef TIKR_FB_XOR_CHK_EN
   output logic [7:0] frame_chk,
`endif
   output logic [7:0] frame_cnt
);

   fb_state_e  state_q, state_d;
   logic [2:0] k_q, k_d;
   ebuf_t      buf_q, buf_d;
   ebuf_t      frame_q, frame_d;
   logic       vld_q, vld_d;
   logic [7:0] cnt_q, cnt_d;
   logic       err_len_q, err_len_d;
   logic       err_tmo_q, err_tmo_d;
   logic       accept, slot_free, write, expire;

   assign in_ready  = rst_n && (state_q != FULL);
   assign accept    = in_valid && in_ready;
   assign slot_free = !vld_q || frame_ack;

   tikr_fb_timer u_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (accept || (state_q != FILL)),
      .en     ((state_q == FILL) && !accept),
      .limit  (8'(FRAME_TIMEOUT)),
      .expire (expire)
   );

   // frame assembly FSM and output slot update
   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      buf_d     = buf_q;
      frame_d   = frame_q;
      vld_d     = vld_q && !frame_ack;
      cnt_d     = cnt_q;
      err_len_d = 1'b0;
      err_tmo_d = 1'b0;
      write     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               buf_d[0] = in_data;
               if (in_last) begin
                  err_len_d = 1'b1;
               end else begin
                  state_d = FILL;
                  k_d     = 3'd1;
               end
            end
         end
         FILL: begin
            if (accept) begin
               buf_d[k_q] = in_data;
               if (k_q == 3'(NELEM - 1)) begin
                  if (!in_last) begin
                     err_len_d = 1'b1;
                     state_d   = DROP;
                  end else if (slot_free) begin
                     write   = 1'b1;
                     state_d = IDLE;
                  end else begin
                     state_d = FULL;
                  end
               end else if (in_last) begin
                  err_len_d = 1'b1;
                  state_d   = IDLE;
               end else begin
                  k_d = k_q + 3'd1;
               end
            end else if (expire) begin
               err_tmo_d = 1'b1;
               state_d   = IDLE;
            end
         end
         FULL: begin
            if (slot_free) begin
               write   = 1'b1;
               state_d = IDLE;
            end
         end
         DROP: begin
            if (accept && in_last) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (write) begin
         frame_d = buf_d;
         vld_d   = 1'b1;
         cnt_d   = cnt_q + 8'd1;
      end
   end

   // state, buffer and output slot registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         k_q       <= '0;
         buf_q     <= '0;
         frame_q   <= '0;
         vld_q     <= 1'b0;
         cnt_q     <= '0;
         err_len_q <= 1'b0;
         err_tmo_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         k_q       <= k_d;
         buf_q     <= buf_d;
         frame_q   <= frame_d;
         vld_q     <= vld_d;
         cnt_q     <= cnt_d;
         err_len_q <= err_len_d;
         err_tmo_q <= err_tmo_d;
      end
   end

   for (genvar g = 0; g < NELEM; g++) begin : g_map
      localparam elem_idx_t IX = elem_idx(g);
      assign frame[2][IX.row][IX.col][2] = frame_q[g];
   end

   assign frame_valid = vld_q;
   assign frame_cnt   = cnt_q;
   assign err_len     = err_len_q;
   assign err_tmo     = err_tmo_q;

`ifdef TIKR_FB_XOR_CHK_EN
   logic [7:0] chk_q, chk_d;

   // check byte follows the slot: loaded only when frame is written
   always_comb begin
      chk_d = chk_q;
      if (write) begin
         chk_d = elem_xor(buf_d);
      end
   end

   // check byte register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chk_q <= '0;
      end else begin
         chk_q <= chk_d;
      end
   end

   assign frame_chk = chk_q;
`endif

endmodule

// File: tb/tb_tikr_frame_builder.sv
// Directed and random bench for tikr_frame_builder (FRAME_TIMEOUT=4).
// Reference model works on byte queues and delivery events.
module tb_tikr_frame_builder;
   import tikr_fb_pkg::*;

   localparam int TMO = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_last;
   logic       in_ready;
   frame_t     frame;
   logic       frame_valid;
   logic       frame_ack;
   logic       err_len;
   logic       err_tmo;
   logic [7:0] frame_cnt;
   logic [7:0] frame_chk;

   tikr_frame_builder #(.FRAME_TIMEOUT(TMO)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_last     (in_last),
      .in_ready    (in_ready),
      .frame       (frame),
      .frame_valid (frame_valid),
      .frame_ack   (frame_ack),
      .err_len     (err_len),
      .err_tmo     (err_tmo),
`ifdef TIKR_FB_XOR_CHK_EN
      .frame_chk   (frame_chk),
`endif
      .frame_cnt   (frame_cnt)
   );

`ifndef TIKR_FB_XOR_CHK_EN
   assign frame_chk = 8'h00;
`endif

   always #5 clk = ~clk;

   logic [47:0] obs_frame;
   assign obs_frame = {frame[2][2][1][2], frame[2][2][0][2],
                       frame[2][3][1][2], frame[2][3][0][2],
                       frame[2][4][1][2], frame[2][4][0][2]};

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0] q[$];
   logic [7:0] pend[6];
   logic [7:0] m_frame[6];
   bit         pending, dropping, m_valid, m_el, m_et;
   logic [7:0] m_cnt, m_chk;
   int         idle;

   task automatic chk(input string tag, input logic [47:0] obs,
                      input logic [47:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [47:0] exp_frame();
      return {m_frame[5], m_frame[4], m_frame[3],
              m_frame[2], m_frame[1], m_frame[0]};
   endfunction

   task automatic model_reset();
      q.delete();
      pending = 0; dropping = 0; m_valid = 0;
      m_el = 0; m_et = 0; idle = 0;
      m_cnt = 8'h00; m_chk = 8'h00;
      for (int i = 0; i < 6; i++) m_frame[i] = 8'h00;
   endtask

   task automatic deliver();
      m_chk = 8'h00;
      for (int i = 0; i < 6; i++) begin
         m_frame[i] = pend[i];
         m_chk = m_chk ^ pend[i];
      end
      m_valid = 1;
      m_cnt = m_cnt + 8'd1;
   endtask

   task automatic model_step(input bit v, input logic [7:0] d,
                             input bit l, input bit a);
      bit acc, sf;
      acc = v && !pending;
      sf = !m_valid || a;
      m_el = 0; m_et = 0;
      if (m_valid && a) m_valid = 0;
      if (pending) begin
         if (sf) begin deliver(); pending = 0; end
      end else if (dropping) begin
         if (acc && l) dropping = 0;
      end else if (acc) begin
         q.push_back(d);
         idle = 0;
         if (q.size() == 6) begin
            if (!l) begin
               m_el = 1; dropping = 1;
            end else begin
               for (int i = 0; i < 6; i++) pend[i] = q[i];
               if (sf) deliver(); else pending = 1;
            end
            q.delete();
         end else if (l) begin
            m_el = 1; q.delete();
         end
      end else if (q.size() > 0) begin
         idle++;
         if (TMO != 0 && idle == TMO) begin
            m_et = 1; q.delete();
         end
      end
   endtask

   task automatic check_outputs();
      chk("frame_valid", 48'(frame_valid), 48'(m_valid));
      chk("frame_cnt", 48'(frame_cnt), 48'(m_cnt));
      chk("err_len", 48'(err_len), 48'(m_el));
      chk("err_tmo", 48'(err_tmo), 48'(m_et));
      chk("frame", obs_frame, exp_frame());
`ifdef TIKR_FB_XOR_CHK_EN
      chk("frame_chk", 48'(frame_chk), 48'(m_chk));
`endif
   endtask

   task automatic tick(input bit v, input logic [7:0] d,
                       input bit l, input bit a);
      in_valid = v; in_data = d; in_last = l; frame_ack = a;
      @(negedge clk);
      chk("in_ready", 48'(in_ready), 48'(!pending));
      @(posedge clk);
      model_step(v, d, l, a);
      #1;
      check_outputs();
   endtask

   task automatic send(input logic [7:0] d, input bit l);
      bit done;
      done = 0;
      for (int i = 0; i < 20 && !done; i++) begin
         done = !pending;
         tick(1, d, l, 0);
      end
      if (!done) begin
         n_cmp++; n_err++;
         $error("FAIL send_timeout observed=stalled expected=accepted");
      end
   endtask

   task automatic check_zero();
      chk("rst_ready", 48'(in_ready), 48'd0);
      chk("rst_valid", 48'(frame_valid), 48'd0);
      chk("rst_cnt", 48'(frame_cnt), 48'd0);
      chk("rst_errs", 48'({err_len, err_tmo}), 48'd0);
      chk("rst_frame", obs_frame, 48'd0);
      chk("rst_chk", 48'(frame_chk), 48'd0);
   endtask

   task automatic do_reset();
      rst_n = 0;
      in_valid = 0; in_last = 0; frame_ack = 0; in_data = 8'h00;
      #1;
      check_zero();
      model_reset();
      @(posedge clk);
      #1 rst_n = 1;
      #1 chk("rel_ready", 48'(in_ready), 48'd1);
   endtask

   initial begin
      bit v, l, a;
      logic [7:0] d;
      do_reset();

      for (int i = 0; i < 6; i++) send(8'(8'h10 + i), i == 5);
      chk("f1_e0", 48'(frame[2][4][0][2]), 48'h10);
      chk("f1_e5", 48'(frame[2][2][1][2]), 48'h15);
      chk("f1_cnt", 48'(frame_cnt), 48'd1);

      for (int i = 0; i < 6; i++) send(8'(8'h20 + i), i == 5);
      chk("full_ready", 48'(in_ready), 48'd0);
      chk("full_old", 48'(frame[2][4][0][2]), 48'h10);
      tick(0, 8'h00, 0, 1);
      chk("f2_e0", 48'(frame[2][4][0][2]), 48'h20);
      chk("f2_cnt", 48'(frame_cnt), 48'd2);
      chk("f2_ready", 48'(in_ready), 48'd1);
      tick(0, 8'h00, 0, 1);

      for (int i = 0; i < 3; i++) send(8'(8'h30 + i), i == 2);
      chk("short_err", 48'(err_len), 48'd1);
      tick(0, 8'h00, 0, 0);
      for (int i = 0; i < 6; i++) send(8'(8'h40 + i), i == 5);
      chk("f3_e3", 48'(frame[2][3][1][2]), 48'h43);
      tick(0, 8'h00, 0, 1);

      for (int i = 0; i < 7; i++) begin
         send(8'(8'h50 + i), i == 6);
         if (i == 5) chk("long_err", 48'(err_len), 48'd1);
      end
      chk("long_novalid", 48'(frame_valid), 48'd0);

      send(8'h60, 0);
      send(8'h61, 0);
      for (int i = 0; i < TMO; i++) tick(0, 8'h00, 0, 0);
      chk("tmo_pulse", 48'(err_tmo), 48'd1);
      tick(0, 8'h00, 0, 0);

      send(8'h70, 0);
      send(8'h71, 0);
      do_reset();

      for (int i = 0; i < 6; i++) send(8'(1 << i), i == 5);
`ifdef TIKR_FB_XOR_CHK_EN
      chk("xor_3f", 48'(frame_chk), 48'h3f);
`endif
      tick(0, 8'h00, 0, 1);

      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 59) == 0) begin
            for (int j = 0; j < 6; j++) tick(0, 8'h00, 0, 0);
         end
         v = ($urandom_range(0, 9) < 7);
         d = 8'($urandom);
         if (q.size() == 5) l = ($urandom_range(0, 9) < 8);
         else l = ($urandom_range(0, 24) == 0);
         a = ($urandom_range(0, 9) < 4);
         tick(v, d, l, a);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
